// File: rtl/hazard_fwd_ctrl.sv
// EX-stage operand forwarding and load-use stall control for a 5-stage RV32I core.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall_cnt output.
module hazard_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic              ex_valid, ex_we, ex_is_load, ex_use_rs1, ex_use_rs2;
    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              mem_valid, mem_we, mem_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_we, wb_is_load;
    logic [REG_AW-1:0] wb_rd;
    logic              ins_bubble;

    // A load still in EX cannot be forwarded yet; hold ID for one cycle.
    assign stall = !flush && id_valid && ex_valid && ex_we && ex_is_load &&
                   (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));

    assign ins_bubble = flush || stall || !id_valid;

    function automatic logic [1:0] fwd_sel(
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input logic              mv,
        input logic              mw,
        input logic [REG_AW-1:0] mrd,
        input logic              wv,
        input logic              ww,
        input logic [REG_AW-1:0] wrd
    );
        if (use_rs && mv && mw && (mrd != '0) && (mrd == rs))
            return 2'b01;
        else if (use_rs && wv && ww && (wrd != '0) && (wrd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    assign fwd_a_sel = ex_valid ? fwd_sel(ex_use_rs1, ex_rs1, mem_valid, mem_we, mem_rd,
                                          wb_valid, wb_we, wb_rd) : 2'b00;
    assign fwd_b_sel = ex_valid ? fwd_sel(ex_use_rs2, ex_rs2, mem_valid, mem_we, mem_rd,
                                          wb_valid, wb_we, wb_rd) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_we       <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_use_rs1  <= 1'b0;
            ex_use_rs2  <= 1'b0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_is_load <= 1'b0;
            mem_rd      <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_is_load  <= 1'b0;
            wb_rd       <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_we       <= mem_we;
            wb_is_load  <= mem_is_load;
            wb_rd       <= mem_rd;
            mem_valid   <= ex_valid;
            mem_we      <= ex_we;
            mem_is_load <= ex_is_load;
            mem_rd      <= ex_rd;
            if (ins_bubble) begin
                ex_valid   <= 1'b0;
                ex_we      <= 1'b0;
                ex_is_load <= 1'b0;
                ex_use_rs1 <= 1'b0;
                ex_use_rs2 <= 1'b0;
                ex_rd      <= '0;
                ex_rs1     <= '0;
                ex_rs2     <= '0;
            end else begin
                ex_valid   <= 1'b1;
                ex_we      <= id_rd_we;
                ex_is_load <= id_is_load;
                ex_use_rs1 <= id_use_rs1;
                ex_use_rs2 <= id_use_rs2;
                ex_rd      <= id_rd;
                ex_rs1     <= id_rs1;
                ex_rs2     <= id_rs2;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

    logic unused_bits;
    assign unused_bits = wb_is_load;
`else
    // WB load flag is architectural state with no consumer in this block.
    logic [CNT_W:0] unused_bits;
    assign unused_bits = {wb_is_load, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: per-cycle vector table plus reset/counter sequences.
module tb_hazard_fwd_ctrl;
    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
    logic          flush = 1'b0;
    logic          stall;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        string         name;
        logic          v;
        logic [AW-1:0] rs1, rs2, rd;
        logic          u1, u2, we, ld, fl;
        logic          es;
        logic [1:0]    ea, eb;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(string n, logic v, int rs1, int rs2, logic u1, logic u2,
                                int rd, logic we, logic ld, logic fl,
                                logic es, logic [1:0] ea, logic [1:0] eb);
        vec_t t;
        t.name = n; t.v = v; t.rs1 = AW'(rs1); t.rs2 = AW'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = AW'(rd); t.we = we; t.ld = ld; t.fl = fl; t.es = es; t.ea = ea; t.eb = eb;
        return t;
    endfunction

    task automatic check(string n, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic drive(logic v, int rs1, int rs2, logic u1, logic u2,
                         int rd, logic we, logic ld, logic fl);
        id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = AW'(rd); id_rd_we = we; id_is_load = ld; flush = fl;
    endtask

    task automatic check_outs(string n, logic es, logic [1:0] ea, logic [1:0] eb);
        check({n, ".stall"}, int'(stall), int'(es));
        check({n, ".a"}, int'(fwd_a_sel), int'(ea));
        check({n, ".b"}, int'(fwd_b_sel), int'(eb));
    endtask

    initial begin
        //            name        v rs1 rs2 u1 u2 rd we ld fl  stall a      b
        vecs[0]  = mk("add5",     1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[1]  = mk("sub_id",   1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[2]  = mk("sub_ex",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b01, 2'b01);
        vecs[3]  = mk("sub_gone", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00);
        vecs[4]  = mk("addi7",    1, 0, 0, 1, 0, 7, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[5]  = mk("nop_a",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00);
        vecs[6]  = mk("or_id",    1, 1, 7, 1, 1, 8, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[7]  = mk("or_wb",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b10);
        vecs[8]  = mk("w7_a",     1, 0, 0, 1, 0, 7, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[9]  = mk("w7_b",     1, 0, 0, 1, 0, 7, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[10] = mk("or2_id",   1, 1, 7, 1, 1, 9, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[11] = mk("or2_mem",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b01);
        vecs[12] = mk("lw3",      1, 1, 0, 1, 0, 3, 1, 1, 0,  0, 2'b00, 2'b00);
        vecs[13] = mk("lu_stall", 1, 3, 2, 1, 1, 4, 1, 0, 0,  1, 2'b00, 2'b00);
        vecs[14] = mk("lu_held",  1, 3, 2, 1, 1, 4, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[15] = mk("lu_ex",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b10, 2'b00);
        vecs[16] = mk("x0_wr",    1, 1, 0, 1, 0, 0, 1, 0, 0,  0, 2'b00, 2'b00);
        vecs[17] = mk("x0_rd_id", 1, 0, 1, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00);
        vecs[18] = mk("x0_rd_ex", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00);
        vecs[19] = mk("fl_lw",    1, 1, 0, 1, 0, 3, 1, 1, 0,  0, 2'b00, 2'b00);
        vecs[20] = mk("fl_use",   1, 3, 0, 1, 0, 4, 1, 0, 1,  0, 2'b00, 2'b00);
        vecs[21] = mk("rd4_id",   1, 4, 0, 1, 0, 12, 1, 0, 0, 0, 2'b00, 2'b00);
        vecs[22] = mk("fl_bub",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00);

        // Reset with a load-use-looking instruction on ID: outputs must stay quiet.
        drive(1, 3, 3, 1, 1, 4, 1, 1, 0);
        #2;
        check_outs("reset", 0, 2'b00, 2'b00);
        @(negedge clk);
        check_outs("reset_held", 0, 2'b00, 2'b00);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].rd, vecs[i].we, vecs[i].ld, vecs[i].fl);
            #1;
            check_outs(vecs[i].name, vecs[i].es, vecs[i].ea, vecs[i].eb);
        end

        // Reset pulsed between edges while a load-use stall is up.
        @(negedge clk); drive(1, 1, 0, 1, 0, 3, 1, 1, 0);
        @(negedge clk); drive(1, 3, 0, 1, 0, 4, 1, 0, 0);
        #1 check("mid_rst.pre_stall", int'(stall), 1);
        rst_n = 1'b0;
        #1 check_outs("mid_rst", 0, 2'b00, 2'b00);
        #1 rst_n = 1'b1;
        // add (rs1=3) enters EX; the load must be gone, so no forward.
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_outs("mid_rst.empty", 0, 2'b00, 2'b00);

`ifdef HAZARD_STALL_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("cnt.reset", int'(stall_cnt), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); drive(1, 1, 0, 1, 0, 3, 1, 1, 0);
            @(negedge clk); drive(1, 3, 0, 1, 0, 4, 1, 0, 0);
            #1 check("cnt.stall", int'(stall), 1);
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (k == 0) check("cnt.one", int'(stall_cnt), 1);
        end
        check("cnt.sat", int'(stall_cnt), 3);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
